// File: rtl/ps_pkg.sv
// rtl/ps_pkg.sv - shared frame-state encoding and frame-bit constants
package ps_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    START    = 2'b01,
    TRANSMIT = 2'b10,
    STOP     = 2'b11
  } ps_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/parallel_to_serial_bit_timer.sv
// rtl/parallel_to_serial_bit_timer.sv - bit-period counter, ticks on the last cycle of each bit
module bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Every state change lands on a tick, so the wrap doubles as the per-state restart.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tick = !clear && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/parallel_to_serial.sv
// rtl/parallel_to_serial.sv - framed serial transmitter: start 0, data LSB first, stop 1
module parallel_to_serial
  import ps_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              ser_out,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  ps_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              ser_q, ser_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ser_d     = ser_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        ser_d  = STOP_BIT;
        busy_d = 1'b0;
        if (load) begin
          shift_d   = din;
          bit_cnt_d = '0;
          state_d   = START;
          ser_d     = START_BIT;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = TRANSMIT;
          ser_d   = shift_q[0];
        end
      end
      TRANSMIT: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = STOP;
            ser_d     = STOP_BIT;
            bit_cnt_d = '0;
          end else begin
            shift_d   = shift_q >> 1;
            ser_d     = shift_q[1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ser_q     <= STOP_BIT;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ser_q     <= ser_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ser_out = ser_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb/tb_parallel_to_serial.sv - self-checking bench for parallel_to_serial at CLKS_PER_BIT 4 and 1
module tb_parallel_to_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ser4, busy4, done4;
  logic       ser1, busy1, done1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  parallel_to_serial #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .load(load), .din(din),
    .ser_out(ser4), .busy(busy4), .done(done4)
  );

  parallel_to_serial #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .din(din),
    .ser_out(ser1), .busy(busy1), .done(done1)
  );

  // Reference: a frame is the 10-bit pattern {stop, data, start}; pos counts cycles since acceptance.
  int         cpb[2] = '{4, 1};
  int         pos[2] = '{-1, -1};
  logic [9:0] frm[2];
  logic [7:0] word[2];
  logic       edone[2] = '{1'b0, 1'b0};
  logic       sq[$];
  int         busy_cycles = 0;
  int         done_pulses = 0;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int i, input logic r, input logic l, input logic [7:0] d);
    edone[i] = 1'b0;
    if (r) begin
      pos[i] = -1;
    end else if (pos[i] < 0) begin
      if (l) begin
        frm[i]  = {1'b1, d, 1'b0};
        word[i] = d;
        pos[i]  = 0;
      end
    end else begin
      pos[i]++;
      if (pos[i] == 10 * cpb[i]) begin
        pos[i]   = -1;
        edone[i] = 1'b1;
      end
    end
  endtask

  function automatic logic exp_ser(input int i);
    if (pos[i] < 0) return 1'b1;
    return frm[i][pos[i] / cpb[i]];
  endfunction

  task automatic step(input logic r, input logic l, input logic [7:0] d);
    logic [9:0] rx;
    rst = r; load = l; din = d;
    @(posedge clk);
    model_edge(0, r, l, d);
    model_edge(1, r, l, d);
    #1;
    chk("ser4",  {9'd0, ser4},  {9'd0, exp_ser(0)});
    chk("busy4", {9'd0, busy4}, {9'd0, pos[0] >= 0});
    chk("done4", {9'd0, done4}, {9'd0, edone[0]});
    chk("ser1",  {9'd0, ser1},  {9'd0, exp_ser(1)});
    chk("busy1", {9'd0, busy1}, {9'd0, pos[1] >= 0});
    chk("done1", {9'd0, done1}, {9'd0, edone[1]});
    if (busy4) busy_cycles++;
    if (done4) done_pulses++;
    sq.push_back(ser1);
    if (sq.size() > 16) void'(sq.pop_front());
    // Deframe the CLKS_PER_BIT=1 line like the downstream receiver would.
    if (edone[1] && sq.size() >= 11) begin
      for (int k = 0; k < 10; k++) rx[k] = sq[sq.size() - 11 + k];
      chk("rx_frame", rx, {1'b1, word[1], 1'b0});
    end
  endtask

  initial begin
    // 1: reset held, then idle
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00);

    // 2: single frame of A5, din scrambled after acceptance
    busy_cycles = 0; done_pulses = 0;
    step(1'b0, 1'b1, 8'hA5);
    for (int k = 0; k < 44; k++) step(1'b0, 1'b0, 8'($urandom));
    chk("busy_len_A5", 10'(busy_cycles), 10'd40);
    chk("done_cnt_A5", 10'(done_pulses), 10'd1);

    // 3: load pulse during a frame is ignored
    done_pulses = 0;
    step(1'b0, 1'b1, 8'h3C);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    for (int k = 0; k < 33; k++) step(1'b0, 1'b0, 8'h00);
    chk("done_cnt_3C", 10'(done_pulses), 10'd1);

    // 4: load held high, back-to-back frames
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 8'h01);
    for (int k = 0; k < 60; k++) step(1'b0, 1'b1, 8'h80);
    for (int k = 0; k < 45; k++) step(1'b0, 1'b0, 8'h00);

    // 5: reset in the middle of data bit 3, then a clean frame
    step(1'b0, 1'b1, 8'hC3);
    for (int k = 0; k < 18; k++) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h5A);
    for (int k = 0; k < 44; k++) step(1'b0, 1'b0, 8'h00);

    // 6: 0x55 (CLKS_PER_BIT=1 line deframed in step)
    step(1'b0, 1'b1, 8'h55);
    for (int k = 0; k < 44; k++) step(1'b0, 1'b0, 8'h00);

    // random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
